// File: rtl/comparador_serial_ctrl.sv
// Bit-serial MSB-first magnitude/equality comparator behind valid/ready handshakes.
// Scans one bit position per clock, stopping at the first differing bit.
module comparador_serial_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             z,
    input  logic             y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             f,
    output logic [CW-1:0]    out_bits,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             z_reg;
    logic             y_reg;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             eq;
    logic             gt;

    // (z,y): 00 equal, 01 greater, 10 less, 11 not equal.
    function automatic logic mode_fn(input logic zz, input logic yy,
                                     input logic e, input logic g);
        case ({zz, yy})
            2'b00:   return e;
            2'b01:   return g;
            2'b10:   return !e && !g;
            default: return !e;
        endcase
    endfunction

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // the operand registers are small flops (not a memory) and are reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            f         <= 1'b0;
            out_bits  <= '0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            z_reg     <= 1'b0;
            y_reg     <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            eq        <= 1'b1;
            gt        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        z_reg    <= z;
                        y_reg    <= y;
                        idx      <= IW'(WIDTH - 1);
                        cnt      <= '0;
                        eq       <= 1'b1;
                        gt       <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (a_reg[idx] != b_reg[idx]) begin
                        eq    <= 1'b0;
                        gt    <= a_reg[idx];
                        state <= DONE;
                    end else if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end

                DONE: begin
                    // First DONE cycle publishes the result; it is then held until taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        f         <= mode_fn(z_reg, y_reg, eq, gt);
                        out_bits  <= cnt;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
